i2c_target_ctrl: RTL and testbench

//  Bus-level sequencer for the I2C target that feeds the FNV hasher. Oversamples SCL/SDA on clk,

---
 rtl/i2c_pkg.sv | 24 ++
 rtl/i2c_line_sync.sv | 69 ++++++
 rtl/i2c_target_ctrl.sv | 230 +++++++++++++++++++++++
 tb/tb_i2c_target_ctrl.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared types for the I2C target: controller states, bus conditions and the R/W bit encoding.
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WRITE,
        WRITE_ACK,
        READ,
        READ_ACK,
        IGNORE
    } i2c_state_t;

    typedef enum logic [1:0] {
        NONE,
        START,
        STOP
    } bus_cond_t;

    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

endpackage

// File: rtl/i2c_line_sync.sv
// SCL/SDA synchronizers, sample-tick divider and tick-qualified SCL edge / START / STOP detection.
module i2c_line_sync
    import i2c_pkg::*;
#(
    parameter int SAMPLE_DIV  = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      scl_in,
    input  logic      sda_in,
    output logic      sda,
    output logic      scl_rise,
    output logic      scl_fall,
    output bus_cond_t cond
);

    localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic [DIV_W-1:0]       div_cnt;
    logic                   tick;
    logic                   scl;
    logic                   scl_prev;
    logic                   sda_prev;

    assign tick = (div_cnt == DIV_W'(SAMPLE_DIV - 1));
    assign scl  = scl_sync[SYNC_STAGES-1];
    assign sda  = sda_sync[SYNC_STAGES-1];

    // Synchronizers and previous-sample flops come out of reset at the idle bus level (high),
    // so releasing reset on an idle bus can never look like a START or STOP.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_sync <= '1;
            sda_sync <= '1;
            div_cnt  <= '0;
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
            if (tick) begin
                div_cnt  <= '0;
                scl_prev <= scl;
                sda_prev <= sda;
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
        end
    end

    assign scl_rise = tick & ~scl_prev & scl;
    assign scl_fall = tick & scl_prev & ~scl;

    always_comb begin
        cond = NONE;
        if (tick && scl_prev && scl) begin
            if (sda_prev && !sda) begin
                cond = START;
            end else if (!sda_prev && sda) begin
                cond = STOP;
            end
        end
    end

endmodule

// File: rtl/i2c_target_ctrl.sv
// I2C target bus sequencer: address/data/ACK FSM, open-drain SDA control and rx/tx byte handshakes.
module i2c_target_ctrl
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEVICE_ADDR = 7'h2A,
    parameter int         SAMPLE_DIV  = 32,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       tx_req,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       start_pulse,
    output logic       stop_pulse,
    output logic       rstart_flag,
    output logic       overflow
);

    logic      sda;
    logic      scl_rise;
    logic      scl_fall;
    bus_cond_t cond;

    i2c_line_sync #(
        .SAMPLE_DIV  (SAMPLE_DIV),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_line_sync (
        .clk      (clk),
        .reset    (reset),
        .scl_in   (scl_in),
        .sda_in   (sda_in),
        .sda      (sda),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .cond     (cond)
    );

    i2c_state_t state, state_n;
    logic [2:0] bit_cnt, bit_cnt_n;
    logic [7:0] shift, shift_n;
    logic       ack_phase, ack_phase_n;
    logic       sda_oe_n;
    logic [7:0] rx_data_n;
    logic       rx_valid_n;
    logic       tx_req_n;
    logic       start_n;
    logic       stop_n;
    logic       rstart_n;
    logic       overflow_n;
    logic [7:0] tx_byte;

    assign tx_byte = tx_valid ? tx_data : 8'hFF;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            shift       <= '0;
            ack_phase   <= 1'b0;
            sda_oe      <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            tx_req      <= 1'b0;
            start_pulse <= 1'b0;
            stop_pulse  <= 1'b0;
            rstart_flag <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            state       <= state_n;
            bit_cnt     <= bit_cnt_n;
            shift       <= shift_n;
            ack_phase   <= ack_phase_n;
            sda_oe      <= sda_oe_n;
            rx_data     <= rx_data_n;
            rx_valid    <= rx_valid_n;
            tx_req      <= tx_req_n;
            start_pulse <= start_n;
            stop_pulse  <= stop_n;
            rstart_flag <= rstart_n;
            overflow    <= overflow_n;
        end
    end

    // ack_phase splits each ACK state into its two SCL falls: the first opens the ACK slot,
    // the second closes it and hands over to the next byte.
    always_comb begin
        // NOTE: every signal gets a default first so no path through this block infers a latch.
        state_n     = state;
        bit_cnt_n   = bit_cnt;
        shift_n     = shift;
        ack_phase_n = ack_phase;
        sda_oe_n    = sda_oe;
        rx_data_n   = rx_data;
        rx_valid_n  = rx_valid & ~rx_ready;
        tx_req_n    = 1'b0;
        start_n     = 1'b0;
        stop_n      = 1'b0;
        rstart_n    = rstart_flag;
        overflow_n  = 1'b0;

        if (cond == START) begin
            state_n     = ADDR;
            bit_cnt_n   = '0;
            shift_n     = '0;
            ack_phase_n = 1'b0;
            sda_oe_n    = 1'b0;
            start_n     = 1'b1;
            rstart_n    = (state != IDLE);
        end else if (cond == STOP) begin
            state_n     = IDLE;
            bit_cnt_n   = '0;
            ack_phase_n = 1'b0;
            sda_oe_n    = 1'b0;
            stop_n      = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                end

                ADDR: begin
                    if (scl_rise) begin
                        shift_n   = {shift[6:0], sda};
                        bit_cnt_n = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state_n = (shift[6:0] == DEVICE_ADDR) ? ADDR_ACK : IGNORE;
                        end
                    end
                end

                ADDR_ACK: begin
                    if (scl_fall) begin
                        if (!ack_phase) begin
                            sda_oe_n    = 1'b1;
                            ack_phase_n = 1'b1;
                        end else begin
                            ack_phase_n = 1'b0;
                            if (shift[0] == RW_READ) begin
                                state_n  = READ;
                                tx_req_n = 1'b1;
                                shift_n  = tx_byte;
                                sda_oe_n = ~tx_byte[7];
                            end else begin
                                state_n  = WRITE;
                                sda_oe_n = 1'b0;
                            end
                        end
                    end
                end

                WRITE: begin
                    if (scl_rise) begin
                        shift_n   = {shift[6:0], sda};
                        bit_cnt_n = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state_n = WRITE_ACK;
                        end
                    end
                end

                WRITE_ACK: begin
                    if (scl_fall) begin
                        if (!ack_phase) begin
                            ack_phase_n = 1'b1;
                            if (!rx_valid || rx_ready) begin
                                rx_data_n  = shift;
                                rx_valid_n = 1'b1;
                                sda_oe_n   = 1'b1;
                            end else begin
                                overflow_n = 1'b1;
                                sda_oe_n   = 1'b0;
                            end
                        end else begin
                            ack_phase_n = 1'b0;
                            sda_oe_n    = 1'b0;
                            state_n     = WRITE;
                        end
                    end
                end

                READ: begin
                    // The byte is shifted left after each master sample, so shift[7] is always the next bit.
                    if (scl_rise) begin
                        shift_n   = {shift[6:0], 1'b0};
                        bit_cnt_n = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state_n = READ_ACK;
                        end
                    end else if (scl_fall) begin
                        sda_oe_n = ~shift[7];
                    end
                end

                READ_ACK: begin
                    if (scl_fall) begin
                        if (!ack_phase) begin
                            sda_oe_n    = 1'b0;
                            ack_phase_n = 1'b1;
                        end else begin
                            ack_phase_n = 1'b0;
                            state_n     = READ;
                            tx_req_n    = 1'b1;
                            shift_n     = tx_byte;
                            sda_oe_n    = ~tx_byte[7];
                        end
                    end else if (scl_rise && ack_phase && sda) begin
                        ack_phase_n = 1'b0;
                        state_n     = IGNORE;
                    end
                end

                IGNORE: begin
                    sda_oe_n = 1'b0;
                end

                default: begin
                    state_n  = IDLE;
                    sda_oe_n = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_target_ctrl.sv
// Self-checking bench: an I2C master with a transaction-level target model, directed scenarios and random traffic.
module tb_i2c_target_ctrl;

    localparam int         DIV = 4;
    localparam int         Q   = 3 * DIV;
    localparam logic [6:0] DEV = 7'h2A;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       scl_m, sda_m;
    logic       scl_in, sda_in;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid, rx_ready;
    logic       tx_req;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       start_pulse, stop_pulse, rstart_flag, overflow;

    always #5 clk = ~clk;

    assign scl_in = scl_m;
    assign sda_in = sda_m & ~sda_oe;

    i2c_target_ctrl #(
        .DEVICE_ADDR (DEV),
        .SAMPLE_DIV  (DIV),
        .SYNC_STAGES (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .scl_in      (scl_in),
        .sda_in      (sda_in),
        .sda_oe      (sda_oe),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .tx_req      (tx_req),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .start_pulse (start_pulse),
        .stop_pulse  (stop_pulse),
        .rstart_flag (rstart_flag),
        .overflow    (overflow)
    );

    // Transaction-level view of the target: which kind of byte the next one is.
    typedef enum {M_IDLE, M_ADDR, M_WR, M_RD, M_IGN} mphase_t;

    mphase_t    mphase;
    logic       exp_drive, exp_rx_valid, exp_rstart, rdy_hold, mid_high;
    logic [7:0] exp_rx_data, exp_tx_byte;
    int         exp_start, exp_stop, exp_txreq, exp_ovf;
    int         cnt_start, cnt_stop, cnt_txreq, cnt_ovf;
    logic       prev_start, prev_stop, prev_txreq, prev_ovf, last_rstart;
    int         n_checks = 0;
    int         n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (start_pulse) begin
            check("start_width", {31'd0, prev_start}, 32'd0);
            check("rstart_flag", {31'd0, rstart_flag}, {31'd0, exp_rstart});
            last_rstart <= rstart_flag;
            cnt_start   <= cnt_start + 1;
        end
        if (stop_pulse) begin
            check("stop_width", {31'd0, prev_stop}, 32'd0);
            cnt_stop <= cnt_stop + 1;
        end
        if (tx_req) begin
            check("tx_req_width", {31'd0, prev_txreq}, 32'd0);
            cnt_txreq <= cnt_txreq + 1;
        end
        if (overflow) begin
            check("overflow_width", {31'd0, prev_ovf}, 32'd0);
            cnt_ovf <= cnt_ovf + 1;
        end
        if (mid_high) begin
            check("sda_oe", {31'd0, sda_oe}, {31'd0, exp_drive});
            check("rx_valid", {31'd0, rx_valid}, {31'd0, exp_rx_valid});
            check("rx_data", {24'd0, rx_data}, {24'd0, exp_rx_data});
        end
        prev_start <= start_pulse;
        prev_stop  <= stop_pulse;
        prev_txreq <= tx_req;
        prev_ovf   <= overflow;
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clock_bit(output logic line);
        wait_clks(Q);
        scl_m = 1'b1;
        wait_clks(Q);
        line = sda_in;
        mid_high = 1'b1;
        wait_clks(1);
        mid_high = 1'b0;
        wait_clks(Q);
        scl_m = 1'b0;
        wait_clks(2);
    endtask

    task automatic set_tx(input logic [7:0] d, input logic v);
        tx_data     = d;
        tx_valid    = v;
        exp_tx_byte = v ? d : 8'hFF;
    endtask

    task automatic consume();
        rx_ready = 1'b1;
        wait_clks(1);
        rx_ready = 1'b0;
        exp_rx_valid = 1'b0;
    endtask

    task automatic check_counts();
        check("start_count", cnt_start, exp_start);
        check("stop_count", cnt_stop, exp_stop);
        check("tx_req_count", cnt_txreq, exp_txreq);
        check("overflow_count", cnt_ovf, exp_ovf);
    endtask

    task automatic bus_start();
        if (!scl_m) begin
            sda_m = 1'b1;
            wait_clks(Q);
            scl_m = 1'b1;
            wait_clks(Q);
        end
        exp_rstart = (mphase != M_IDLE);
        exp_start++;
        mphase = M_ADDR;
        sda_m = 1'b0;
        wait_clks(Q);
        scl_m = 1'b0;
        wait_clks(2);
    endtask

    task automatic bus_stop();
        sda_m = 1'b0;
        wait_clks(Q);
        scl_m = 1'b1;
        wait_clks(Q);
        sda_m = 1'b1;
        exp_stop++;
        mphase = M_IDLE;
        wait_clks(Q);
        check_counts();
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic line;
        logic exp_ack;
        for (int i = 7; i >= 0; i--) begin
            sda_m = b[i];
            exp_drive = 1'b0;
            clock_bit(line);
        end
        sda_m = 1'b1;
        case (mphase)
            M_ADDR:  exp_ack = (b[7:1] == DEV);
            M_WR:    exp_ack = !exp_rx_valid || rdy_hold;
            default: exp_ack = 1'b0;
        endcase
        exp_drive = exp_ack;
        if (mphase == M_ADDR) begin
            if (!exp_ack) mphase = M_IGN;
            else if (b[0]) begin
                mphase = M_RD;
                exp_txreq++;
            end else mphase = M_WR;
        end else if (mphase == M_WR) begin
            if (exp_ack) begin
                exp_rx_data  = b;
                exp_rx_valid = !rdy_hold;
            end else begin
                exp_ovf++;
            end
        end
        clock_bit(line);
        ack = !line;
        check("ack", {31'd0, ack}, {31'd0, exp_ack});
        exp_drive = 1'b0;
    endtask

    task automatic recv_byte(input logic master_ack, input logic [7:0] nd, input logic nv,
                             output logic [7:0] b);
        logic line;
        sda_m = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            exp_drive = ~exp_tx_byte[i];
            clock_bit(line);
            b[i] = line;
        end
        check("rd_byte", {24'd0, b}, {24'd0, exp_tx_byte});
        if (master_ack) begin
            set_tx(nd, nv);
            exp_txreq++;
        end else begin
            mphase = M_IGN;
        end
        sda_m = !master_ack;
        exp_drive = 1'b0;
        clock_bit(line);
        sda_m = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       ack;
        logic [7:0] b;
        logic       line;
        int         base;

        scl_m = 1'b1; sda_m = 1'b1; rx_ready = 1'b0; tx_data = 8'h00; tx_valid = 1'b0;
        mid_high = 1'b0; rdy_hold = 1'b0; exp_drive = 1'b0;
        mphase = M_IDLE; exp_rx_valid = 1'b0; exp_rx_data = 8'h00; exp_rstart = 1'b0; exp_tx_byte = 8'hFF;
        exp_start = 0; exp_stop = 0; exp_txreq = 0; exp_ovf = 0;
        cnt_start = 0; cnt_stop = 0; cnt_txreq = 0; cnt_ovf = 0;
        prev_start = 1'b0; prev_stop = 1'b0; prev_txreq = 1'b0; prev_ovf = 1'b0; last_rstart = 1'b0;

        #2 reset = 1'b1;
        wait_clks(3);
        check("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
        check("rst_outputs", {20'd0, rx_data, rx_valid, tx_req, start_pulse, stop_pulse},
              32'd0);
        check("rst_flags", {30'd0, rstart_flag, overflow}, 32'd0);
        reset = 1'b0;
        wait_clks(Q);

        // 1: write 0x61 to 0x2A
        bus_start();
        send_byte(8'h54, ack);
        check("t1_addr_ack", {31'd0, ack}, 32'd1);
        send_byte(8'h61, ack);
        check("t1_data_ack", {31'd0, ack}, 32'd1);
        bus_stop();
        wait_clks(20);
        check("t1_rx_data", {24'd0, rx_data}, 32'h61);
        check("t1_rx_valid_held", {31'd0, rx_valid}, 32'd1);
        consume();
        wait_clks(1);
        check("t1_rx_valid_clr", {31'd0, rx_valid}, 32'd0);

        // 2: wrong address
        bus_start();
        send_byte(8'h56, ack);
        check("t2_addr_nack", {31'd0, ack}, 32'd0);
        send_byte(8'h00, ack);
        check("t2_data_nack", {31'd0, ack}, 32'd0);
        base = cnt_stop;
        bus_stop();
        check("t2_stop_pulse", cnt_stop - base, 32'd1);

        // 3: overflow
        base = cnt_ovf;
        bus_start();
        check("t3_after_stop_idle", {31'd0, last_rstart}, 32'd0);
        send_byte(8'h54, ack);
        send_byte(8'h11, ack);
        check("t3_first_ack", {31'd0, ack}, 32'd1);
        send_byte(8'h22, ack);
        check("t3_second_nack", {31'd0, ack}, 32'd0);
        bus_stop();
        check("t3_overflow_once", cnt_ovf - base, 32'd1);
        check("t3_rx_data_kept", {24'd0, rx_data}, 32'h11);
        consume();

        // 4: read 0xA5 then 0xFF
        base = cnt_txreq;
        set_tx(8'hA5, 1'b1);
        bus_start();
        send_byte(8'h55, ack);
        check("t4_addr_ack", {31'd0, ack}, 32'd1);
        recv_byte(1'b1, 8'h3C, 1'b0, b);
        check("t4_byte0", {24'd0, b}, 32'hA5);
        recv_byte(1'b0, 8'h00, 1'b0, b);
        check("t4_byte1", {24'd0, b}, 32'hFF);
        bus_stop();
        check("t4_tx_req_count", cnt_txreq - base, 32'd2);

        // 5: repeated START into a read
        bus_start();
        send_byte(8'h54, ack);
        send_byte(8'h3C, ack);
        bus_start();
        wait_clks(Q);
        check("t5_rstart", {31'd0, last_rstart}, 32'd1);
        set_tx(8'h5A, 1'b1);
        send_byte(8'h55, ack);
        check("t5_read_ack", {31'd0, ack}, 32'd1);
        recv_byte(1'b0, 8'h00, 1'b0, b);
        check("t5_read_byte", {24'd0, b}, 32'h5A);
        bus_stop();
        consume();

        // 6: reset during bit 4 of a read byte
        set_tx(8'h00, 1'b1);
        bus_start();
        send_byte(8'h55, ack);
        sda_m = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_drive = 1'b1;
            clock_bit(line);
        end
        wait_clks(Q);
        scl_m = 1'b1;
        wait_clks(Q);
        check("t6_driving", {31'd0, sda_oe}, 32'd1);
        reset = 1'b1;
        #1;
        check("t6_reset_release", {31'd0, sda_oe}, 32'd0);
        mphase = M_IDLE; exp_rx_valid = 1'b0; exp_rx_data = 8'h00; exp_drive = 1'b0;
        wait_clks(Q);
        reset = 1'b0;
        wait_clks(Q);
        bus_start();
        send_byte(8'h54, ack);
        check("t6_recover_ack", {31'd0, ack}, 32'd1);
        bus_stop();
        consume();

        // Random traffic
        for (int t = 0; t < 20; t++) begin
            logic [6:0] a;
            logic       rw;
            int         nb;
            int         mode;
            a  = ($urandom_range(0, 1) == 1) ? DEV : 7'($urandom);
            rw = 1'($urandom);
            nb = $urandom_range(1, 3);
            set_tx(8'($urandom), $urandom_range(0, 3) != 0);
            bus_start();
            send_byte({a, rw}, ack);
            if (mphase == M_WR) begin
                for (int j = 0; j < nb; j++) begin
                    mode = $urandom_range(0, 2);
                    if (mode == 1) consume();
                    if (mode == 2) begin
                        rx_ready = 1'b1; rdy_hold = 1'b1; exp_rx_valid = 1'b0;
                    end
                    send_byte(8'($urandom), ack);
                    rx_ready = 1'b0; rdy_hold = 1'b0;
                end
            end else if (mphase == M_RD) begin
                for (int j = 0; j < nb; j++) begin
                    recv_byte(j < nb - 1, 8'($urandom), $urandom_range(0, 3) != 0, b);
                end
            end else begin
                send_byte(8'($urandom), ack);
            end
            if (t == 19 || $urandom_range(0, 3) != 0) bus_stop();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
